// File: rtl/issue_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | issue_queue_if : rename -> issue queue -> register-read bundle            |
// | Stats outputs present only when ISSQ_STATS_EN is defined.  Rev 1.0        |
// +--------------------------------------------------------------------------+
interface issue_queue_if #(
    parameter int ISSUE_ENTRY_SIZE = 192,
    parameter int PTR_W            = 4,
    parameter int PREG_W           = 6
);
    logic                        FREEZE;
    logic                        mispredict;
    logic                        flush_fCOM;
    logic                        in_valid;
    logic [ISSUE_ENTRY_SIZE-1:0] in_entry;
    logic                        in_ready;
    logic                        wb_valid;
    logic [PREG_W-1:0]           wb_reg;
    logic [ISSUE_ENTRY_SIZE-1:0] issue_entry;
    logic                        issue_valid;
    logic [PTR_W:0]              count;
    logic                        full;
    logic                        empty;

`ifdef ISSQ_STATS_EN
    logic [31:0]                 stall_cycles;
    logic [31:0]                 full_cycles;
    logic [31:0]                 issued_count;

    modport master (
        output FREEZE, mispredict, flush_fCOM, in_valid, in_entry, wb_valid, wb_reg,
        input  in_ready, issue_entry, issue_valid, count, full, empty,
               stall_cycles, full_cycles, issued_count
    );
    modport slave (
        input  FREEZE, mispredict, flush_fCOM, in_valid, in_entry, wb_valid, wb_reg,
        output in_ready, issue_entry, issue_valid, count, full, empty,
               stall_cycles, full_cycles, issued_count
    );
`else
    modport master (
        output FREEZE, mispredict, flush_fCOM, in_valid, in_entry, wb_valid, wb_reg,
        input  in_ready, issue_entry, issue_valid, count, full, empty
    );
    modport slave (
        input  FREEZE, mispredict, flush_fCOM, in_valid, in_entry, wb_valid, wb_reg,
        output in_ready, issue_entry, issue_valid, count, full, empty
    );
`endif
endinterface
`default_nettype wire

// File: rtl/issue_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | issue_queue : in-order issue queue with 64-entry register scoreboard      |
// | Optional counters via ISSQ_STATS_EN.  Rev 1.0                             |
// +--------------------------------------------------------------------------+
module issue_queue #(
    parameter int ISSUE_ENTRY_SIZE = 192,
    parameter int DEPTH            = 16,
    parameter int PTR_W            = 4,
    parameter int PREG_NUM         = 64
) (
    input  wire logic    CLK,
    input  wire logic    RESET,
    issue_queue_if.slave bus
);
    localparam int             PREG_W    = $clog2(PREG_NUM);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [ISSUE_ENTRY_SIZE-1:0] mem [DEPTH];
    logic [PTR_W-1:0]            head;
    logic [PTR_W-1:0]            tail;
    logic [PTR_W:0]              occ;
    logic [PREG_NUM-1:0]         rdy;
    logic [PREG_NUM-1:0]         rdy_next;
    logic [ISSUE_ENTRY_SIZE-1:0] out_entry;
    logic                        out_valid;

    logic [ISSUE_ENTRY_SIZE-1:0] head_entry;
    logic [PREG_W-1:0]           dest;
    logic [PREG_W-1:0]           src_a;
    logic [PREG_W-1:0]           src_b;
    logic                        writes;
    logic                        need_a;
    logic                        need_b;
    logic                        a_ok;
    logic                        b_ok;
    logic                        head_ready;
    logic                        full_q;
    logic                        empty_q;
    logic                        flush;
    logic                        push;
    logic                        pop;

    always_comb begin
        head_entry = mem[head];
        dest       = head_entry[179:174];
        src_b      = head_entry[173:168];
        src_a      = head_entry[166:161];
        writes     = head_entry[140];
        need_a     = !(head_entry[139] | head_entry[128]);
        need_b     = !(head_entry[132] | head_entry[139] | head_entry[128]);
        a_ok       = (src_a == '0) || rdy[src_a];
        b_ok       = (src_b == '0) || rdy[src_b];
    end

    assign full_q     = (occ == DEPTH_CNT);
    assign empty_q    = (occ == '0);
    assign flush      = bus.mispredict | bus.flush_fCOM;
    assign head_ready = !empty_q && (!need_a || a_ok) && (!need_b || b_ok);
    assign pop        = head_ready && !bus.FREEZE && !flush;
    // Acceptance looks only at registered occupancy: a full queue refuses even when popping.
    assign push       = bus.in_valid && !full_q && !flush;

    // Issue clear is applied after the writeback set so the newer producer wins.
    always_comb begin
        rdy_next = rdy;
        if (bus.wb_valid) begin
            rdy_next[bus.wb_reg] = 1'b1;
        end
        if (pop && writes && (dest != '0)) begin
            rdy_next[dest] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[tail] <= bus.in_entry;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head      <= '0;
            tail      <= '0;
            occ       <= '0;
            out_entry <= '0;
            out_valid <= 1'b0;
            rdy       <= '1;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            occ       <= '0;
            out_entry <= '0;
            out_valid <= 1'b0;
            rdy       <= '1;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (!bus.FREEZE) begin
                out_entry <= pop ? head_entry : '0;
                out_valid <= pop;
            end
            case ({push, pop})
                2'b10:   occ <= occ + (PTR_W + 1)'(1);
                2'b01:   occ <= occ - (PTR_W + 1)'(1);
                default: occ <= occ;
            endcase
            rdy <= rdy_next;
        end
    end

    assign bus.in_ready    = !full_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.count       = occ;
    assign bus.issue_entry = out_entry;
    assign bus.issue_valid = out_valid;

`ifdef ISSQ_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] full_cnt;
    logic [31:0] issued_cnt;

    // Counters survive flushes; only the hard reset clears them.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_cnt  <= '0;
            full_cnt   <= '0;
            issued_cnt <= '0;
        end else begin
            if (!empty_q && !bus.FREEZE && !head_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (full_q && bus.in_valid) begin
                full_cnt <= full_cnt + 32'd1;
            end
            if (pop) begin
                issued_cnt <= issued_cnt + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = stall_cnt;
    assign bus.full_cycles  = full_cnt;
    assign bus.issued_count = issued_cnt;
`endif

endmodule
`default_nettype wire
